array_streamer: RTL
===================

Name: array_streamer

Overview:
- Transmit end of the number/valid/last stream consumed by the two-sum solver.
- Loads an array through a write port into an internal buffer, then on `start` plays it out one element per cycle with `number_last` on the final element, holding `target` stable for the whole stream.
- Captures the solver's `index1`/`index2`/`index_valid` result for the stream it sent and reports `found`/`done` to the bench or host.

Parameters:
DATA_WIDTH, 2, signed element/target width
ARRAY_SIZE, 2**DATA_WIDTH, buffer depth (max elements per stream)
INDEX_WIDTH, $clog2(ARRAY_SIZE), index width

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
wr_data  in  DATA_WIDTH  signed element to load
wr_valid  in  1  load strobe
wr_last  in  1  final element of load; valid only with wr_valid
start  in  1  begin streaming loaded array
target_in  in  DATA_WIDTH  signed target, sampled on accepted start
pause  in  1  suppress emission this cycle (creates gaps)
number  out  DATA_WIDTH  signed streamed element
number_valid  out  1  element strobe
number_last  out  1  final element; only high with number_valid
target  out  DATA_WIDTH  latched target, stable during STREAM
index_valid  in  1  solver result strobe
index1  in  INDEX_WIDTH  solver index of later element
index2  in  INDEX_WIDTH  solver index of earlier element
found  out  1  result captured for current stream
found_index1  out  INDEX_WIDTH  captured index1
found_index2  out  INDEX_WIDTH  captured index2
busy  out  1  state == STREAM
done  out  1  one-cycle pulse, cycle after number_last beat

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, length = 0.
- All outputs 0 after reset: number, number_valid, number_last, target, found, found_index1, found_index2, busy, done.
- States: IDLE, LOADED, STREAM.
- IDLE / LOADED, write:
  - wr_valid writes mem[wr_ptr] and increments wr_ptr.
  - wr_valid in LOADED first resets wr_ptr to 0, i.e. starts a fresh load overwriting from index 0.
  - wr_valid&wr_last, or wr_ptr==ARRAY_SIZE-1 (forced last): length=wr_ptr+1, wr_ptr=0, go LOADED.
- Start:
  - `start` is accepted only in LOADED and only when wr_valid is low; a same-cycle write wins and start is ignored.
  - Accepted start: target<=target_in; rd_ptr=0; found, found_index1/2 cleared; go STREAM.
  - `start` in IDLE or STREAM is ignored.
- STREAM:
  - Each cycle with !pause: number<=mem[rd_ptr]; number_valid<=1; number_last<=(rd_ptr==length-1); rd_ptr++.
  - Cycle with pause: number_valid<=0, number_last<=0; number holds its value.
  - Outputs are registered: start accepted at edge N gives first beat at edge N+1 when pause is low.
  - After the last beat is issued: rd_ptr=0, go LOADED, done pulses the following cycle.
  - The loaded array is replayable by a new start.
- Writes during STREAM are ignored.
- number_last never high without number_valid.
- target changes only on an accepted start.
- Result capture:
  - First index_valid while found==0, in STREAM or the cycle after the last beat: latch found_index1/2, found<=1.
  - Later index_valid ignored until the next start.
- rst mid-stream: next cycle number_valid=0 and state IDLE; buffer contents are don't-care, length=0.
- Arithmetic: pointers wrap modulo ARRAY_SIZE but never exceed length-1; number and target are passed bit-exact, no sign extension.

Optional Feature:
- Macro: EARLY_STOP_EN.
- Defined:
  - In STREAM, once found==1, the next emitted beat carries number_last=1 regardless of rd_ptr.
  - The stream terminates there (go LOADED, done pulses).
  - The solver still receives a clean last so its cache clears.
- Undefined: the full array is always streamed; found has no effect on emission.

Decomposition:
- Shared package: state encoding (IDLE/LOADED/STREAM) and INDEX_WIDTH derivation, reused by the solver's formal harness.
- Natural sub-module: array_buffer, a simple dual-port register file with sync write and async read, depth ARRAY_SIZE, width DATA_WIDTH.
- Sequencer/FSM and result capture stay in array_streamer.

Test Plan:
- Load [1,-2,0,1] (wr_last on 4th), start with target_in=-1, pause=0 -> beats 1,-2,0,1 on 4 consecutive cycles starting the cycle after start; number_last on 4th only; target=-1 throughout; done one cycle after 4th beat.
- Same array chained to solver -> solver gives index1=1, index2=0 -> found=1, found_index1=1, found_index2=0; second start clears found then recaptures identical values.
- Load 3 elements [0,1,-1], pause high on cycles 2 and 3 of stream -> number_valid pattern 1,0,0,1,1; number_last only on the third emitted beat (value -1).
- Load 5 writes with no wr_last (ARRAY_SIZE=4) -> length forced to 4 at 4th write; 5th write starts a new load at index 0; start is ignored until the new load's last.
- rst asserted on 2nd beat -> number_valid=0 next cycle; busy=0; start with no reload is ignored (IDLE).
- EARLY_STOP_EN, array [1,-2,0,1], target -1, index_valid returned after beat 2 -> next emitted beat has number_last=1; no further beats; done pulses.

Source files
------------

// File: rtl/array_streamer_pkg.sv
// Shared definitions for the array streamer: sequencer state encoding and
// index-width derivation (also used by the two-sum solver's formal harness).
package array_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    STREAM = 2'd2
  } state_t;

  // A depth-1 buffer still needs a one-bit index.
  function automatic int index_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/array_streamer_buffer.sv
// array_buffer: simple dual-port register file, synchronous write and
// asynchronous read, holding the array to be streamed.
module array_buffer #(
  parameter int DATA_WIDTH  = 2,
  parameter int ARRAY_SIZE  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  logic [DATA_WIDTH-1:0] mem [ARRAY_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/array_streamer.sv
// Loads an array, streams it as number/valid/last with a held target, and
// captures the solver's index result. Define EARLY_STOP_EN to cut the stream short once a result is found.
module array_streamer
  import array_streamer_pkg::*;
#(
  parameter int DATA_WIDTH  = 2,
  parameter int ARRAY_SIZE  = 2 ** DATA_WIDTH,
  parameter int INDEX_WIDTH = index_width(ARRAY_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_valid,
  input  logic                   wr_last,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  target_in,
  input  logic                   pause,
  output logic [DATA_WIDTH-1:0]  number,
  output logic                   number_valid,
  output logic                   number_last,
  output logic [DATA_WIDTH-1:0]  target,
  input  logic                   index_valid,
  input  logic [INDEX_WIDTH-1:0] index1,
  input  logic [INDEX_WIDTH-1:0] index2,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] found_index1,
  output logic [INDEX_WIDTH-1:0] found_index2,
  output logic                   busy,
  output logic                   done
);

  localparam int LEN_W = INDEX_WIDTH + 1;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] wr_ptr;
  logic [INDEX_WIDTH-1:0] rd_ptr;
  logic [LEN_W-1:0]       length;
  logic [INDEX_WIDTH-1:0] wr_addr;
  logic [INDEX_WIDTH-1:0] last_idx;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   wr_en;
  logic                   load_end;
  logic                   start_ok;
  logic                   capture_window;
  logic                   capture;
  logic                   stop_now;
  logic                   at_last;

  // A write arriving in LOADED begins a fresh load at index 0.
  assign wr_addr  = (state == LOADED) ? '0 : wr_ptr;
  assign wr_en    = wr_valid && (state != STREAM);
  assign load_end = wr_en && (wr_last || (wr_addr == INDEX_WIDTH'(ARRAY_SIZE - 1)));
  assign start_ok = start && !wr_valid && (state == LOADED);
  assign last_idx = INDEX_WIDTH'(length - LEN_W'(1));

  // The solver may answer while the final beat is on the bus or one cycle later.
  assign capture_window = (state == STREAM) || (number_valid && number_last) || done;
  assign capture        = index_valid && !found && capture_window && !start_ok;

`ifdef EARLY_STOP_EN
  assign stop_now = found || capture;
`else
  assign stop_now = 1'b0;
`endif

  assign at_last = (rd_ptr == last_idx) || stop_now;
  assign busy    = (state == STREAM);

  array_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_SIZE (ARRAY_SIZE),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_buffer (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      length       <= '0;
      number       <= '0;
      number_valid <= 1'b0;
      number_last  <= 1'b0;
      target       <= '0;
      found        <= 1'b0;
      found_index1 <= '0;
      found_index2 <= '0;
      done         <= 1'b0;
    end else begin
      done <= number_valid && number_last;

      if (capture) begin
        found        <= 1'b1;
        found_index1 <= index1;
        found_index2 <= index2;
      end

      case (state)
        IDLE, LOADED: begin
          number_valid <= 1'b0;
          number_last  <= 1'b0;
          if (wr_en) begin
            if (load_end) begin
              length <= LEN_W'(wr_addr) + LEN_W'(1);
              wr_ptr <= '0;
              state  <= LOADED;
            end else begin
              wr_ptr <= wr_addr + INDEX_WIDTH'(1);
              state  <= IDLE;
            end
          end else if (start_ok) begin
            target       <= target_in;
            rd_ptr       <= '0;
            found        <= 1'b0;
            found_index1 <= '0;
            found_index2 <= '0;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (!pause) begin
            number       <= rd_data;
            number_valid <= 1'b1;
            number_last  <= at_last;
            if (at_last) begin
              rd_ptr <= '0;
              state  <= LOADED;
            end else begin
              rd_ptr <= rd_ptr + INDEX_WIDTH'(1);
            end
          end else begin
            number_valid <= 1'b0;
            number_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
